bin_bcd_seq: RTL and testbench
==============================

Name: bin_bcd_seq

Overview:
Sequential shift-add-3 (double-dabble) converter. It turns the signed 32-bit calculator result into 10 BCD digits plus a sign flag. It sits directly downstream of calc_4_func and feeds the display-packing logic ahead of Disp_7seg. It replaces the combinational converter with a multi-cycle engine that has an explicit start/busy/done handshake.

Parameters:
BIN_W, 32, width of the two's-complement input operand
DIGITS, 10, number of BCD output digits; must satisfy 10^DIGITS > 2^(BIN_W-1)

Ports:
clk  in  1  system clock; all state updates on posedge clk
rst  in  1  synchronous reset, active-high
start  in  1  request a conversion; sampled only in IDLE
bin_2s  in  BIN_W  two's-complement operand; captured on the accepting edge
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse; bcd_out/neg valid from this cycle on
bcd_out  out  4*DIGITS  result digits; [3:0] = least significant digit
neg  out  1  1 when the captured operand was negative
blank_mask  out  DIGITS  leading-zero mask (see Optional Feature)

Behaviour:
- Reset: synchronous and active-high, as already decided. With rst high at a posedge: state=IDLE, busy=0, done=0, bcd_out=0, neg=0, blank_mask=0, shift counter=0. Reset beats start.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at the edge:
  - magnitude register <= bin_2s[BIN_W-1] ? (~bin_2s+1) : bin_2s, treated as unsigned BIN_W bits (so 0x80000000 -> 2147483648).
  - neg_work <= bin_2s[BIN_W-1]; BCD work register <= 0; counter <= 0; busy <= 1; state -> SHIFT.
- SHIFT, one edge per bit:
  - Every digit of the work register that is >=5 gets +3 (4-bit add, no carry between digits).
  - Then {work, magnitude} shifts left by 1.
  - counter increments. When counter==BIN_W-1 at the edge, state -> DONE.
- DONE, one edge:
  - bcd_out <= work; neg <= neg_work; blank_mask updated; done <= 1; busy <= 0; state -> IDLE.
- Timing: start sampled high at the end of cycle 0. busy is high in cycles 1..BIN_W+1 (1..33 at default). done is high in cycle BIN_W+2 only (34 at default).
- done is a single-cycle pulse; it clears on the next edge regardless of start.
- bcd_out, neg and blank_mask hold their last result until the next DONE edge. They do not clear at start.
- start while busy (SHIFT/DONE) is ignored and not queued. bin_2s changes after capture have no effect.
- start high in the same cycle done is high: state is IDLE, so it is accepted. Back-to-back throughput is one result per BIN_W+2 cycles.
- Holding start high continuously restarts a conversion every BIN_W+2 cycles.
- rst mid-conversion: aborts immediately, no done pulse, outputs cleared as above.
- Zero input: bcd_out=0, neg=0. Negative zero cannot occur.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: at the DONE edge, blank_mask[i]=1 for every digit i above the most significant nonzero digit; digit 0 is never blanked. The mask is computed combinationally from work and registered with bcd_out.
- Undefined: blank_mask is tied to 0 and no mask logic is present. The port list is identical in both builds.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4
  - default BIN_W/DIGITS constants
  - state typedef enum {IDLE, SHIFT, DONE}
  - BCD_MINUS=4'hA and BCD_EQUALS=4'hB display codes, shared with the display path
- Sub-module bcd_add3: 4-bit digit in, corrected digit out (+3 if >=5). Instantiated DIGITS times via generate.

Test Plan:
1. rst 2 cycles, then start with bin_2s=32'd0 -> busy cycles 1..33, done pulse in cycle 34 only, bcd_out=40'h0000000000, neg=0, blank_mask=0.
2. bin_2s=32'd1234567890 -> bcd_out=40'h1234567890, neg=0. Then 32'h7FFFFFFF -> 40'h2147483647, neg=0.
3. bin_2s=32'hFFFFFF85 (-123) -> bcd_out=40'h0000000123, neg=1. Then 32'h80000000 -> 40'h2147483648, neg=1.
4. start with 32'd42 in cycle 0, start with 32'd99 in cycle 10 -> second ignored; single done in cycle 34 with 40'h0000000042. Start 32'd7 in cycle 34 -> accepted, done in cycle 68 with 40'h0000000007.
5. Complete 32'd55, then start 32'd8 and assert rst in cycle 20 -> busy=0 and bcd_out=0 from cycle 21; no done pulse through cycle 60.
6. LEADING_ZERO_BLANK_EN defined: 32'd405 -> blank_mask=10'b1111111000; 32'd0 -> 10'b1111111110; 32'd1000000000 -> 10'b0000000000. Undefined: blank_mask=0 for all three.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD widths, default sizes, converter states and display codes
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W_DEF = 32;
  localparam int DIGITS_DEF = 10;
  localparam logic [3:0] BCD_MINUS = 4'hA;
  localparam logic [3:0] BCD_EQUALS = 4'hB;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  // correct the digit so the following left shift carries into the next decade
  always_comb q = (d >= BCD_DIGIT_W'(5)) ? d + BCD_DIGIT_W'(3) : d;
endmodule

// File: rtl/bin_bcd_seq.sv
// bin_bcd_seq: sequential signed binary to BCD converter; LEADING_ZERO_BLANK_EN enables blank_mask
module bin_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_2s,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          neg,
  output logic [DIGITS-1:0]             blank_mask
);
  localparam int CW = $clog2(BIN_W);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  state_t state, state_nx;
  logic [BIN_W-1:0] mag;
  logic [BW-1:0] work, adj;
  logic [CW-1:0] cnt;
  logic neg_work;
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d(work[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, one SHIFT per operand bit, one DONE cycle
  always_comb begin
    state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
               (state == SHIFT) ? ((cnt == CW'(BIN_W - 1)) ? DONE : SHIFT) : IDLE;
  end
  // datapath: capture magnitude, shift-add-3 per bit, publish result on DONE
  always_ff @(posedge clk)
    if (rst) begin
      mag <= '0;
      work <= '0;
      cnt <= '0;
      neg_work <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd_out <= '0;
      neg <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        mag <= bin_2s[BIN_W-1] ? (~bin_2s + BIN_W'(1)) : bin_2s;
        neg_work <= bin_2s[BIN_W-1];
        work <= '0;
        cnt <= '0;
        busy <= 1'b1;
      end else if (state == SHIFT) begin
        work <= {adj[BW-2:0], mag[BIN_W-1]};
        mag <= mag << 1;
        cnt <= cnt + CW'(1);
      end else if (state == DONE) begin
        bcd_out <= work;
        neg <= neg_work;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] mask_c;
  assign mask_c[0] = 1'b0;
  for (i = 1; i < DIGITS; i++) begin : g_mask
    assign mask_c[i] = ~|work[BW-1:i*BCD_DIGIT_W];
  end
  // leading-zero mask is registered together with bcd_out
  always_ff @(posedge clk)
    if (rst) blank_mask <= '0;
    else if (state == DONE) blank_mask <= mask_c;
`else
  assign blank_mask = '0;
`endif
endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb_bin_bcd_seq: scoreboard bench for bin_bcd_seq
module tb_bin_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] bin_2s = '0;
  logic busy, done, neg;
  logic [39:0] bcd_out;
  logic [9:0] blank_mask;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [39:0] bcd;
    logic        neg;
    logic [9:0]  mask;
  } exp_t;
  exp_t sb[$];

  bin_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin_2s(bin_2s),
    .busy(busy), .done(done), .bcd_out(bcd_out), .neg(neg), .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    longint m, mm, p;
    m = longint'({32'b0, v});
    if (v[31]) m = 64'h1_0000_0000 - m;
    mm = m;
    e.neg = v[31];
    for (int k = 0; k < 10; k++) begin
      e.bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    p = 10;
    for (int k = 1; k < 10; k++) begin
      e.mask[k] = (mm < p);
      p = p * 10;
    end
`else
    p = mm;
`endif
    return e;
  endfunction

  always @(negedge clk)
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
        chk("neg", 64'(neg), 64'(e.neg));
        chk("blank_mask", 64'(blank_mask), 64'(e.mask));
      end
    end

  task automatic convert(input logic [31:0] v);
    @(negedge clk);
    start = 1'b1;
    bin_2s = v;
    sb.push_back(model(v));
    @(negedge clk);
    start = 1'b0;
    bin_2s = $urandom;
    for (int k = 1; k <= 33; k++) begin
      chk("busy_during", 64'(busy), 1);
      chk("done_early", 64'(done), 0);
      if (k < 33) @(negedge clk);
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 1);
    chk("busy_end", 64'(busy), 0);
    @(negedge clk);
    chk("done_single", 64'(done), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_bcd", 64'(bcd_out), 0);
    chk("rst_neg", 64'(neg), 0);
    chk("rst_mask", 64'(blank_mask), 0);
    convert(32'd0);
    convert(32'd1234567890);
    convert(32'h7FFFFFFF);
    convert(32'hFFFFFF85);
    convert(32'h80000000);
    convert(32'd405);
    convert(32'd1000000000);
    // start ignored while busy; start accepted in the done cycle
    @(negedge clk);
    start = 1'b1;
    bin_2s = 32'd42;
    sb.push_back(model(32'd42));
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    bin_2s = 32'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    chk("t4_done34", 64'(done), 1);
    start = 1'b1;
    bin_2s = 32'd7;
    sb.push_back(model(32'd7));
    @(negedge clk);
    start = 1'b0;
    chk("t4_busy35", 64'(busy), 1);
    repeat (32) @(negedge clk);
    chk("t4_busy67", 64'(busy), 1);
    chk("t4_nodone67", 64'(done), 0);
    @(negedge clk);
    chk("t4_done68", 64'(done), 1);
    // reset mid-conversion aborts without a done pulse
    convert(32'd55);
    @(negedge clk);
    start = 1'b1;
    bin_2s = 32'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy21", 64'(busy), 0);
    chk("t5_bcd21", 64'(bcd_out), 0);
    chk("t5_neg21", 64'(neg), 0);
    rst = 1'b0;
    for (int k = 22; k <= 60; k++) begin
      @(negedge clk);
      chk("t5_nodone", 64'(done), 0);
    end
    convert(32'hFFFFFFFF);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
